hex_ascii_loader: RTL

- Front end of the HEX2BIN datapath. Consumes a byte-wide ASCII character stream over a valid/ready handshake.
- Decodes hex digit characters to 4-bit nibbles and drives a downstream chain of 4-bit enable/clear registers. The chain is wired as a shift register: reg[0].D = NIB, reg[i].D = reg[i-1].Q, all EN = SHIFT, all CLR = REG_CLR.
- Frames multi-digit entries, counts digits, and flags malformed input.

---
 rtl/hex_ascii_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/hex_ascii_loader.sv
// HEX2BIN front end: decodes an ASCII hex character stream into nibbles and
// drives a shift-register chain of 4-bit enable/clear registers.
module hex_ascii_loader #(
  parameter int DIGITS = 4,
  parameter int CW     = 4
) (
  input  logic          CLK,
  input  logic          CLR_N,
  input  logic [7:0]    CHAR,
  input  logic          CHAR_VLD,
  output logic          CHAR_RDY,
  output logic [3:0]    NIB,
  output logic          SHIFT,
  output logic          REG_CLR,
  output logic [CW-1:0] CNT,
  output logic          DONE,
  output logic          ERR
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;
  localparam logic [1:0] ST_ERROR = 2'd3;

  localparam logic [2:0] CLS_DIGIT   = 3'd0;
  localparam logic [2:0] CLS_CR      = 3'd1;
  localparam logic [2:0] CLS_ESC     = 3'd2;
  localparam logic [2:0] CLS_BLANK   = 3'd3;
  localparam logic [2:0] CLS_INVALID = 3'd4;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nib_q, nib_d;
  logic          shift_q, shift_d;
  logic          reg_clr_q, reg_clr_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;

  logic [2:0]    char_class;
  logic [3:0]    char_val;
  logic          accept;

  always_comb begin
    char_class = CLS_INVALID;
    char_val   = 4'd0;
    if (CHAR >= 8'h30 && CHAR <= 8'h39) begin
      char_class = CLS_DIGIT;
      char_val   = CHAR[3:0];
    end else if ((CHAR >= 8'h41 && CHAR <= 8'h46) || (CHAR >= 8'h61 && CHAR <= 8'h66)) begin
      char_class = CLS_DIGIT;
      char_val   = CHAR[3:0] + 4'd9;
    end else if (CHAR == 8'h0D) begin
      char_class = CLS_CR;
    end else if (CHAR == 8'h1B) begin
      char_class = CLS_ESC;
    end else if (CHAR == 8'h20 || CHAR == 8'h0A) begin
      char_class = CLS_BLANK;
    end
  end

  assign accept = CHAR_VLD && rdy_q;

  // The first digit is parked in nib_q during CLEAR so the chain is zeroed
  // before that digit is shifted in; CLR would otherwise swallow it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    nib_d     = nib_q;
    err_d     = err_q;
    shift_d   = 1'b0;
    reg_clr_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (char_class)
            CLS_DIGIT: begin
              nib_d     = char_val;
              cnt_d     = '0;
              reg_clr_d = 1'b1;
              state_d   = ST_CLEAR;
            end
            CLS_ESC: begin
              cnt_d     = '0;
              reg_clr_d = 1'b1;
            end
            CLS_INVALID: begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end
            default: ;
          endcase
        end
      end
      ST_CLEAR: begin
        shift_d = 1'b1;
        cnt_d   = CW'(1);
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          case (char_class)
            CLS_DIGIT: begin
              if (cnt_q < CW'(DIGITS)) begin
                nib_d   = char_val;
                shift_d = 1'b1;
                cnt_d   = cnt_q + CW'(1);
              end else begin
                err_d   = 1'b1;
                state_d = ST_ERROR;
              end
            end
            CLS_CR: begin
              done_d  = 1'b1;
              state_d = ST_IDLE;
            end
            CLS_ESC: begin
              cnt_d     = '0;
              reg_clr_d = 1'b1;
              state_d   = ST_IDLE;
            end
            CLS_INVALID: begin
              err_d   = 1'b1;
              state_d = ST_ERROR;
            end
            default: ;
          endcase
        end
      end
      default: begin
        if (accept && (char_class == CLS_CR || char_class == CLS_ESC)) begin
          err_d     = 1'b0;
          cnt_d     = '0;
          reg_clr_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
    endcase
    rdy_d = (state_d != ST_CLEAR);
  end

  // Reset leaves REG_CLR high so the chain is zero once reset is released.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      nib_q     <= 4'd0;
      shift_q   <= 1'b0;
      reg_clr_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdy_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      nib_q     <= nib_d;
      shift_q   <= shift_d;
      reg_clr_q <= reg_clr_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdy_q     <= rdy_d;
    end
  end

  assign CHAR_RDY = rdy_q;
  assign NIB      = nib_q;
  assign SHIFT    = shift_q;
  assign REG_CLR  = reg_clr_q;
  assign CNT      = cnt_q;
  assign DONE     = done_q;
  assign ERR      = err_q;

endmodule
